// File: rtl/gray_seq_ctrl_pkg.sv
// Shared types and helpers for the Gray-code sequencer: command opcodes, FSM states
// and the binary-to-Gray conversion used by the step core.
package gray_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_STOP  = 2'b00,
        OP_RUN   = 2'b01,
        OP_BURST = 2'b10,
        OP_LOAD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2
    } state_e;

    localparam int GRAY_MAX_W = 32;

    // Operates on a 32-bit container; callers zero-extend and keep the low bits.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// Command port of the Gray-code sequencer, grouped so host and sequencer share one bundle.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready; the host
// holds cmd_valid and all cmd_* fields stable until that edge, and cmd_ready never depends on cmd_valid.
interface gray_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_dir;
    logic [LEN_W-1:0] cmd_len;
    logic [WIDTH-1:0] cmd_load;

    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_len, cmd_load,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_len, cmd_load,
        output cmd_ready
    );
endinterface

// File: rtl/gray_seq_ctrl_step_core.sv
// Binary counter with a registered Gray shadow; load has priority over step, and wrap is
// a pulse registered together with the step that crosses max<->0.
module gray_step_core
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    logic [WIDTH-1:0]      bin_nxt;
    logic [WIDTH-1:0]      bin_sel;
    logic                  wrap_nxt;
    logic [GRAY_MAX_W-1:0] gray_full;
    logic                  unused_gray_hi;

    always_comb begin
        bin_nxt  = dir ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));
        wrap_nxt = dir ? (&bin) : (~|bin);
        bin_sel  = load ? load_val : bin_nxt;
    end

    // Gray is computed from the value being written so it can never lag bin.
    assign gray_full      = bin2gray(GRAY_MAX_W'(bin_sel));
    assign unused_gray_hi = ^gray_full[GRAY_MAX_W-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            bin  <= bin_sel;
            gray <= gray_full[WIDTH-1:0];
            wrap <= 1'b0;
        end else if (step) begin
            bin  <= bin_sel;
            gray <= gray_full[WIDTH-1:0];
            wrap <= wrap_nxt;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Command-driven Gray-code sequencer: FSM, burst length counter, handshake and pulse outputs
// around a gray_step_core that owns the count.
module gray_seq_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    gray_seq_ctrl_if.slave    cmd,
    input  logic              hold,
    output logic [WIDTH-1:0]  bin_out,
    output logic [WIDTH-1:0]  gray_out,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic              cmd_err,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_RUN   = S_RUN;
    localparam logic [1:0] ST_BURST = S_BURST;

    logic [1:0]       state_q, state_d;
    logic             dir_q, dir_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             done_d, err_d;
    logic             step, load, accept;
    op_e              op;

    assign cmd.cmd_ready = (state_q != ST_BURST);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign op            = op_e'(cmd.cmd_op);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        len_d   = len_q;
        step    = 1'b0;
        load    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD: load = 1'b1;
                        OP_RUN: begin
                            dir_d   = cmd.cmd_dir;
                            state_d = ST_RUN;
                        end
                        OP_BURST: begin
                            if (cmd.cmd_len != '0) begin
                                dir_d   = cmd.cmd_dir;
                                len_d   = cmd.cmd_len;
                                state_d = ST_BURST;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // STOP wins over hold and suppresses the step on its own accept edge.
                if (accept && op == OP_STOP) begin
                    state_d = ST_IDLE;
                end else begin
                    step  = !hold;
                    err_d = accept;
                end
            end
            ST_BURST: begin
                if (!hold) begin
                    step  = 1'b1;
                    len_d = len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            len_q   <= '0;
            done    <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            done    <= done_d;
            cmd_err <= err_d;
        end
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_BURST);
    assign fsm_state = state_q;

    gray_step_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .dir      (dir_q),
        .load     (load),
        .load_val (cmd.cmd_load),
        .bin      (bin_out),
        .gray     (gray_out),
        .wrap     (wrap)
    );

endmodule
